// File: rtl/brick_pkg.sv
// Shared definitions for the brick-health writer: default widths, the
// writer FSM state encoding and the saturating accumulator helper.
package brick_pkg;

    localparam int BRICK_N_DEF       = 40;
    localparam int BRICK_ADDR_W      = 6;
    localparam int BRICK_HEALTH_W    = 2;
    localparam int BRICK_INIT_HEALTH = 3;
    localparam int TOTAL_W           = 10;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RD   = 2'd2,
        ST_WR   = 2'd3
    } brick_state_e;

    // Add two totals, clamping at the all-ones value instead of wrapping.
    function automatic logic [TOTAL_W-1:0] sat_add(
        input logic [TOTAL_W-1:0] a,
        input logic [TOTAL_W-1:0] b
    );
        logic [TOTAL_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[TOTAL_W] ? {TOTAL_W{1'b1}} : sum[TOTAL_W-1:0];
    endfunction

endpackage

// File: rtl/brick_init_seq.sv
// Level-load sequencer: walks the brick addresses 0..N_BRICKS-1 while the
// FSM enables it, accumulates total_health and raises init_done after the
// last brick. start restarts it from address 0 with a cleared total.
module brick_init_seq
    import brick_pkg::*;
#(
    parameter int N_BRICKS    = BRICK_N_DEF,
    parameter int ADDR_W      = BRICK_ADDR_W,
    parameter int INIT_HEALTH = BRICK_INIT_HEALTH
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               en,
    output logic [ADDR_W-1:0]  cnt,
    output logic               done,
    output logic [TOTAL_W-1:0] total_health,
    output logic               init_done
);

    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(N_BRICKS - 1);
    localparam logic [TOTAL_W-1:0] INIT_INC  = TOTAL_W'(INIT_HEALTH);

    // done marks the cycle in which the final brick is being written.
    assign done = en && (cnt == LAST_ADDR);

    // Address counter, running total and completion flag; start wins over en.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt          <= '0;
            total_health <= '0;
            init_done    <= 1'b0;
        end else if (start) begin
            cnt          <= '0;
            total_health <= '0;
            init_done    <= 1'b0;
        end else if (en) begin
            total_health <= sat_add(total_health, INIT_INC);
            if (cnt == LAST_ADDR) begin
                cnt       <= '0;
                init_done <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/brick_hit_writer.sv
// Brick-health RAM owner. Fills every brick with INIT_HEALTH on level load,
// then serves hits as read-modify-write decrements, one game_write pulse per
// health point removed. Optional feature macro: REDRAW_NOTIFY_EN adds a
// redraw_valid/redraw_addr pulse alongside every hit write.
//
// Hit handshake (valid/ready): a hit transfers on the rising edge where
// hit_valid && hit_ready are both high and hit_addr is captured on that edge;
// the source holds hit_valid and hit_addr stable until then. hit_ready is
// high only in IDLE. A level_load in the same cycle swallows the hit.
module brick_hit_writer
    import brick_pkg::*;
#(
    parameter int N_BRICKS    = BRICK_N_DEF,
    parameter int ADDR_W      = BRICK_ADDR_W,
    parameter int HEALTH_W    = BRICK_HEALTH_W,
    parameter int INIT_HEALTH = BRICK_INIT_HEALTH
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                level_load,
    input  logic                hit_valid,
    output logic                hit_ready,
    input  logic [ADDR_W-1:0]   hit_addr,
    output logic [ADDR_W-1:0]   mem_rd_addr,
    input  logic [HEALTH_W-1:0] mem_rd_data,
    output logic                mem_wr_en,
    output logic [ADDR_W-1:0]   mem_wr_addr,
    output logic [HEALTH_W-1:0] mem_wr_data,
    output logic                game_write,
    output logic [TOTAL_W-1:0]  total_health,
    output logic                init_done,
    output logic                redraw_valid,
    output logic [ADDR_W-1:0]   redraw_addr
);

    localparam logic [ADDR_W:0]     N_EXT    = (ADDR_W + 1)'(N_BRICKS);
    localparam logic [HEALTH_W-1:0] INIT_VAL = HEALTH_W'(INIT_HEALTH);

    brick_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] init_cnt;
    logic              init_last;
    logic              init_wr;
    logic              hit_fire;
    logic              hit_in_range;
    logic              rmw_wr;

    // Writes during INIT are held off while reset is asserted so the RAM
    // sees nothing until the block is released; level_load aborts any write.
    assign init_wr      = resetn && (state_q == ST_INIT) && !level_load;
    assign hit_fire     = hit_valid && hit_ready && !level_load;
    assign hit_in_range = ({1'b0, hit_addr} < N_EXT);
    assign rmw_wr       = (state_q == ST_WR) && !level_load && (mem_rd_data != '0);

    brick_init_seq #(
        .N_BRICKS   (N_BRICKS),
        .ADDR_W     (ADDR_W),
        .INIT_HEALTH(INIT_HEALTH)
    ) u_init_seq (
        .clk         (clk),
        .resetn      (resetn),
        .start       (level_load),
        .en          (init_wr),
        .cnt         (init_cnt),
        .done        (init_last),
        .total_health(total_health),
        .init_done   (init_done)
    );

    // State register and captured hit address.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_INIT;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (hit_fire && hit_in_range) begin
                addr_q <= hit_addr;
            end
        end
    end

    // Next-state selection; level_load forces a fresh initialisation.
    always_comb begin
        state_d = state_q;
        if (level_load) begin
            state_d = ST_INIT;
        end else begin
            unique case (state_q)
                ST_INIT: if (init_last) state_d = ST_IDLE;
                ST_IDLE: if (hit_fire && hit_in_range) state_d = ST_RD;
                ST_RD:   state_d = ST_WR;
                ST_WR:   state_d = ST_IDLE;
                default: state_d = ST_INIT;
            endcase
        end
    end

    // RAM port and pulse outputs decoded from the current state.
    always_comb begin
        hit_ready   = (state_q == ST_IDLE);
        mem_rd_addr = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        game_write  = 1'b0;
        if (state_q == ST_RD) begin
            mem_rd_addr = addr_q;
        end
        if (init_wr) begin
            mem_wr_en   = 1'b1;
            mem_wr_addr = init_cnt;
            mem_wr_data = INIT_VAL;
        end else if (rmw_wr) begin
            mem_wr_en   = 1'b1;
            mem_wr_addr = addr_q;
            mem_wr_data = mem_rd_data - 1'b1;
            game_write  = 1'b1;
        end
    end

`ifdef REDRAW_NOTIFY_EN
    assign redraw_valid = rmw_wr;
    assign redraw_addr  = rmw_wr ? addr_q : '0;
`else
    assign redraw_valid = 1'b0;
    assign redraw_addr  = '0;
`endif

endmodule

// File: tb/tb_brick_hit_writer.sv
// Bench for brick_hit_writer: synchronous RAM model, per-brick health model,
// expected write-event queue and a negedge monitor that pops and compares.
module tb_brick_hit_writer;

  localparam int N        = 40;
  localparam int ADDR_W   = 6;
  localparam int HEALTH_W = 2;
  localparam int INIT_H   = 3;
  localparam int EV_W     = 2 + 2 * ADDR_W + 1 + HEALTH_W;
  localparam int TOTAL_EXP = (N * INIT_H > 1023) ? 1023 : N * INIT_H;
`ifdef REDRAW_NOTIFY_EN
  localparam bit RV = 1'b1;
`else
  localparam bit RV = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                resetn;
  logic                level_load;
  logic                hit_valid;
  logic                hit_ready;
  logic [ADDR_W-1:0]   hit_addr;
  logic [ADDR_W-1:0]   mem_rd_addr;
  logic [HEALTH_W-1:0] mem_rd_data;
  logic                mem_wr_en;
  logic [ADDR_W-1:0]   mem_wr_addr;
  logic [HEALTH_W-1:0] mem_wr_data;
  logic                game_write;
  logic [9:0]          total_health;
  logic                init_done;
  logic                redraw_valid;
  logic [ADDR_W-1:0]   redraw_addr;

  logic [HEALTH_W-1:0] ram [0:(1<<ADDR_W)-1];
  logic [EV_W-1:0]     exp_q[$];
  int                  health [0:N-1];
  int                  checks = 0;
  int                  errors = 0;
  int                  gw_seen = 0;
  int                  rv_seen = 0;
  int                  gw_exp = 0;

  brick_hit_writer dut (
    .clk         (clk),
    .resetn      (resetn),
    .level_load  (level_load),
    .hit_valid   (hit_valid),
    .hit_ready   (hit_ready),
    .hit_addr    (hit_addr),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .game_write  (game_write),
    .total_health(total_health),
    .init_done   (init_done),
    .redraw_valid(redraw_valid),
    .redraw_addr (redraw_addr)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // synchronous RAM, one-cycle read latency
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
    mem_rd_data <= ram[mem_rd_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EV_W-1:0] mk_ev(input logic gw, input logic rv,
      input logic [ADDR_W-1:0] ra, input logic en, input logic [ADDR_W-1:0] wa,
      input logic [HEALTH_W-1:0] wd);
    return {gw, rv, ra, en, wa, wd};
  endfunction

  // reference model: every brick back to full, 40 fill writes expected
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      health[i] = INIT_H;
      exp_q.push_back(mk_ev(1'b0, 1'b0, '0, 1'b1, ADDR_W'(i), HEALTH_W'(INIT_H)));
    end
  endtask

  // reference model: a hit removes one point from a live brick
  task automatic model_hit(input int a);
    if (a < N && health[a] > 0) begin
      health[a]--;
      gw_exp++;
      exp_q.push_back(mk_ev(1'b1, RV, RV ? ADDR_W'(a) : '0, 1'b1, ADDR_W'(a),
                            HEALTH_W'(health[a])));
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (resetn && (mem_wr_en || game_write || redraw_valid)) begin
      logic [EV_W-1:0] act;
      act = mk_ev(game_write, redraw_valid, redraw_addr, mem_wr_en, mem_wr_addr, mem_wr_data);
      if (game_write) gw_seen++;
      if (redraw_valid) rv_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %0h expected none at %0t", act, $time);
      end else begin
        chk("write_event", 32'(act), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // wait for init_done, counting negedges from the current point
  task automatic wait_init(input int exp_n);
    int n = 0;
    while (!init_done && n < 4 * N) begin
      @(negedge clk);
      n++;
    end
    chk("init_cycles", 32'(n), 32'(exp_n));
    chk("total_health", 32'(total_health), 32'(TOTAL_EXP));
    chk("ready_after_init", 32'(hit_ready), 32'd1);
  endtask

  // driver: one hit; abort=1 fires level_load during the read cycle
  task automatic do_hit(input int a, input bit abort);
    int  n = 0;
    bit  exp_wr;
    @(negedge clk);
    hit_valid = 1'b1;
    hit_addr  = ADDR_W'(a);
    while (!hit_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!hit_ready) begin
      chk("hit_ready_timeout", 32'd0, 32'd1);
      hit_valid = 1'b0;
      return;
    end
    exp_wr = (!abort && a < N && health[a] > 0);
    if (!abort) model_hit(a);
    @(negedge clk);
    hit_valid = 1'b0;
    hit_addr  = ADDR_W'($urandom);
    if (a < N) begin
      chk("rd_addr", 32'(mem_rd_addr), 32'(a));
      chk("ready_low_rd", 32'(hit_ready), 32'd0);
      if (abort) begin
        level_load = 1'b1;
        model_reset();
      end
      @(negedge clk);
      level_load = 1'b0;
      chk("game_write_t2", 32'(game_write), 32'(exp_wr));
      if (abort) begin
        chk("init_done_fall", 32'(init_done), 32'd0);
        chk("total_cleared", 32'(total_health), 32'd0);
        wait_init(N);
      end else begin
        chk("wr_en_t2", 32'(mem_wr_en), 32'(exp_wr));
      end
    end else begin
      chk("oor_ready", 32'(hit_ready), 32'd1);
      chk("oor_no_access", 32'({mem_wr_en, game_write, mem_rd_addr}), 32'd0);
    end
  endtask

  // driver: level_load pulse, optionally with a competing hit in the same cycle
  task automatic do_load(input bit with_hit);
    @(negedge clk);
    level_load = 1'b1;
    if (with_hit) begin
      chk("ready_before_load", 32'(hit_ready), 32'd1);
      hit_valid = 1'b1;
      hit_addr  = ADDR_W'(3);
    end
    model_reset();
    @(negedge clk);
    level_load = 1'b0;
    hit_valid  = 1'b0;
    chk("load_init_done_low", 32'(init_done), 32'd0);
    chk("load_no_read", 32'(mem_rd_addr), 32'd0);
    wait_init(N);
  endtask

  initial begin
    int g0, r0;
    int order [0:N-1];
    resetn     = 1'b0;
    level_load = 1'b0;
    hit_valid  = 1'b0;
    hit_addr   = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = HEALTH_W'($urandom);
    idle(3);
    chk("reset_flags", 32'({hit_ready, mem_wr_en, game_write, init_done, redraw_valid}), 32'd0);
    chk("reset_buses", 32'({mem_rd_addr, mem_wr_addr, mem_wr_data, redraw_addr}), 32'd0);
    chk("reset_total", 32'(total_health), 32'd0);

    // 1: fill after reset release (first write sample comes one negedge later)
    model_reset();
    @(posedge clk);
    #2 resetn = 1'b1;
    wait_init(N + 1);

    // 2: brick 5 twice (3 -> 2, then re-read 2 -> 1)
    do_hit(5, 1'b0);
    idle(1);
    chk("ram5_after_hit", 32'(ram[5]), 32'd2);
    do_hit(5, 1'b0);

    // 3: brick 7 four times, last one is dead
    idle(1);
    g0 = gw_seen;
    for (int k = 0; k < 4; k++) do_hit(7, 1'b0);
    idle(1);
    chk("brick7_pulses", 32'(gw_seen - g0), 32'd3);

    // 4: out-of-range address is consumed silently
    do_hit(45, 1'b0);

    // 5: level_load while brick 9 is being read
    do_hit(9, 1'b1);
    idle(1);
    chk("ram9_refilled", 32'(ram[9]), 32'(INIT_H));

    // randomized hits, some out of range, random gaps
    for (int k = 0; k < 60; k++) begin
      do_hit($urandom_range(0, N + 7), 1'b0);
      idle($urandom_range(0, 3));
    end

    // level_load wins over a simultaneous hit
    do_load(1'b1);

    // 6: every brick three times in shuffled rounds
    idle(1);
    g0 = gw_seen;
    r0 = rv_seen;
    for (int rnd = 0; rnd < INIT_H; rnd++) begin
      for (int i = 0; i < N; i++) order[i] = i;
      for (int i = N - 1; i > 0; i--) begin
        int j, t;
        j = $urandom_range(0, i);
        t = order[i]; order[i] = order[j]; order[j] = t;
      end
      for (int i = 0; i < N; i++) do_hit(order[i], 1'b0);
    end
    idle(2);
    chk("sweep_pulses", 32'(gw_seen - g0), 32'd120);
    chk("sweep_redraw", 32'(rv_seen - r0), RV ? 32'd120 : 32'd0);
    chk("total_constant", 32'(total_health), 32'(TOTAL_EXP));
    do_hit(0, 1'b0);
    idle(2);
    chk("pulses_total", 32'(gw_seen), 32'(gw_exp));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
